wav_dfi_phy_hs_responder: RTL
=============================

Name: wav_dfi_phy_hs_responder

Overview:
PHY-side end of the DFI control handshakes. It answers controller-initiated low-power requests (lp_ctrl and lp_data) and controller updates (ctrlupd), and it initiates PHY updates (phyupd) from an internal PHY trigger. It sits between the DFI pins and the PHY's internal sequencer. Its outputs must satisfy the DFI control assertions as the handshake partner of the DFI MC driver.

Parameters:
LP_ACK_DLY, 2, cycles from lp_*_req sampled high to lp_*_ack assertion (1..TLP_RESP-1).
TLP_RESP, 8, window in which lp_*_ack must assert; the ack is never raised after this many req cycles.
CTRLUPD_ACK_DLY, 1, cycles from ctrlupd_req rise to ctrlupd_ack.
UPD_HOLD, 4, cycles phyupd_req stays high after phyupd_ack is first seen.
TPHYUPD_RESP, 16, cycles allowed from phyupd_req to phyupd_ack before timeout is flagged.

Ports:
clock  in  1  DFI clock.
reset  in  1  synchronous, active-high reset.
lp_ctrl_req  in  1  controller LP request.
lp_ctrl_wakeup  in  6  wakeup code.
lp_ctrl_ack  out  1  LP acknowledge.
lp_data_req  in  1  data-path LP request.
lp_data_wakeup  in  6  wakeup code.
lp_data_ack  out  1  acknowledge.
ctrlupd_req  in  1  controller update request.
ctrlupd_ack  out  1  controller update acknowledge.
phyupd_req  out  1  PHY update request.
phyupd_type  out  2  PHY update type.
phyupd_ack  in  1  controller grant.
init_start  in  1  DFI init in progress.
phy_busy  in  1  PHY cannot enter LP; blocks lp acks.
upd_trig  in  1  one-cycle pulse that starts a PHY update.
upd_trig_type  in  2  type captured with upd_trig.
lp_ctrl_wakeup_q  out  6  wakeup code latched at lp_ctrl_ack.
lp_data_wakeup_q  out  6  wakeup code latched at lp_data_ack.
phyupd_timeout  out  1  one-cycle pulse when the tphyupd_resp window expires.

Behaviour:
- Reset: all outputs 0 and all FSMs IDLE on the next clock edge. Reset applied mid-operation aborts the handshake with the same result.
- LP FSM (one independent instance each for ctrl and data): IDLE -> WAIT -> ACK -> IDLE.
  - IDLE -> WAIT: req=1 and init_start=0. The counter starts at 0.
  - WAIT: counts cycles with req=1 and phy_busy=0. When the count reaches LP_ACK_DLY, go to ACK, assert ack on the next edge and latch wakeup into *_wakeup_q.
  - WAIT, req drops: return to IDLE with no ack.
  - WAIT, total req cycles reach TLP_RESP without ack: go to IDLE and never ack for this req. The controller must drop req; a new rise starts over.
  - ACK: ack is held while req=1. A wakeup change while in ACK re-latches *_wakeup_q.
  - ACK, req sampled 0: ack deasserts on the next edge (registered), then IDLE.
- ctrlupd:
  - ack_q sets CTRLUPD_ACK_DLY cycles after ctrlupd_req is sampled high, but only if phyupd_req=0 and init_start=0.
  - ctrlupd_ack = ack_q & ctrlupd_req, gated combinationally so ack never outlives req.
  - ack_q clears when req is sampled 0.
  - If a PHY update is in progress, ctrlupd waits; ack is never given while phyupd_req=1.
- phyupd FSM: IDLE -> REQ -> HOLD -> DROP -> IDLE.
  - IDLE, upd_trig=1 and ack_q=0 and init_start=0: phyupd_req=1 next edge; upd_trig_type is captured into phyupd_type. A trigger arriving while not IDLE, or while blocked, is dropped.
  - REQ: waits for phyupd_ack. An internal counter counts request cycles. When the counter equals TPHYUPD_RESP, phyupd_timeout pulses once; the FSM keeps waiting.
  - HOLD: entered when phyupd_ack=1. Stays UPD_HOLD cycles, then phyupd_req=0.
  - DROP: waits for phyupd_ack=0, then IDLE. phyupd_type returns to 0 in IDLE.
  - Simultaneous upd_trig and ctrlupd_req rise in IDLE: phyupd wins and ctrlupd_ack stays held off.

Optional Feature:
- Macro: WAV_DFI_PHYMSTR_EN.
- Defined:
  - Adds ports phymstr_req out 1, phymstr_type out 2, phymstr_cs_state out 2, phymstr_state_sel out 1, phymstr_ack in 1, mstr_trig in 1, mstr_trig_type in 2.
  - A PHY-master FSM with the same structure as phyupd (REQ/HOLD/DROP, UPD_HOLD cycles).
  - The PHY-master FSM and phyupd are mutually exclusive: a trigger is dropped while the other FSM is not IDLE.
  - phymstr_cs_state=2'b11 and phymstr_state_sel=0 while phymstr_req=1, else 0.
- Not defined: these ports and that logic are absent.

Test Plan:
- lp_ctrl_req=1 held, wakeup=6'h05, LP_ACK_DLY=2 -> lp_ctrl_ack=1 at the third edge, lp_ctrl_wakeup_q=6'h05; req drops -> ack=0 one edge later.
- lp_data_req=1 with phy_busy=1 for 10 cycles, TLP_RESP=8 -> lp_data_ack stays 0; req drop and re-rise with phy_busy=0 -> ack after 2 cycles.
- ctrlupd_req pulse of 5 cycles -> ack high in cycles 2-5; ack=0 in the same cycle req falls.
- upd_trig, type=2'b01; phyupd_ack returned after 3 cycles -> phyupd_req high 3+4 cycles, type=01; req falls, ack falls -> IDLE.
- upd_trig with no phyupd_ack for 20 cycles -> phyupd_timeout pulses exactly at cycle 16; req stays high; later ack completes normally.
- reset=1 asserted during lp_ctrl ACK and phyupd HOLD -> all outputs 0 on the next edge; init_start=1 with lp_ctrl_req=1 -> no ack.

Source files
------------

// File: rtl/wav_dfi_phy_hs_responder.sv
// wav_dfi_phy_hs_responder: PHY-side DFI handshakes (lp_ctrl/lp_data, ctrlupd, phyupd); WAV_DFI_PHYMSTR_EN adds a PHY-master requester
module wav_dfi_phy_hs_lp #(
    parameter int ACK_DLY = 2,
    parameter int RESP    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       init_start,
    input  logic       phy_busy,
    input  logic [5:0] wakeup,
    output logic       ack,
    output logic [5:0] wakeup_q
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [7:0] DLY8  = 8'(ACK_DLY);
    localparam logic [7:0] RESP8 = 8'(RESP);
    state_t     state;
    logic [7:0] dly_cnt, req_cnt;
    logic       stale;
    // Request/ack FSM; stale blocks a timed-out request until the controller drops it
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ack      <= 1'b0;
            wakeup_q <= 6'd0;
            dly_cnt  <= 8'd0;
            req_cnt  <= 8'd0;
            stale    <= 1'b0;
        end else begin
            if (!req) stale <= 1'b0;
            case (state)
                IDLE: if (req && !init_start && !stale) begin
                    state   <= WAIT;
                    dly_cnt <= 8'd0;
                    req_cnt <= 8'd1;
                end
                WAIT: if (!req) state <= IDLE;
                else if (req_cnt + 8'd1 >= RESP8) begin
                    state <= IDLE;
                    stale <= 1'b1;
                end else if (!phy_busy && dly_cnt + 8'd1 == DLY8) begin
                    state    <= ACK;
                    ack      <= 1'b1;
                    wakeup_q <= wakeup;
                end else begin
                    req_cnt <= req_cnt + 8'd1;
                    if (!phy_busy) dly_cnt <= dly_cnt + 8'd1;
                end
                ACK: if (req) wakeup_q <= wakeup;
                else begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module wav_dfi_phy_hs_responder #(
    parameter int LP_ACK_DLY      = 2,
    parameter int TLP_RESP        = 8,
    parameter int CTRLUPD_ACK_DLY = 1,
    parameter int UPD_HOLD        = 4,
    parameter int TPHYUPD_RESP    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lp_ctrl_req,
    input  logic [5:0] lp_ctrl_wakeup,
    output logic       lp_ctrl_ack,
    input  logic       lp_data_req,
    input  logic [5:0] lp_data_wakeup,
    output logic       lp_data_ack,
    input  logic       ctrlupd_req,
    output logic       ctrlupd_ack,
    output logic       phyupd_req,
    output logic [1:0] phyupd_type,
    input  logic       phyupd_ack,
    input  logic       init_start,
    input  logic       phy_busy,
    input  logic       upd_trig,
    input  logic [1:0] upd_trig_type,
    output logic [5:0] lp_ctrl_wakeup_q,
    output logic [5:0] lp_data_wakeup_q,
    output logic       phyupd_timeout
`ifdef WAV_DFI_PHYMSTR_EN
    ,
    output logic       phymstr_req,
    output logic [1:0] phymstr_type,
    output logic [1:0] phymstr_cs_state,
    output logic       phymstr_state_sel,
    input  logic       phymstr_ack,
    input  logic       mstr_trig,
    input  logic [1:0] mstr_trig_type
`endif
);
    typedef enum logic [1:0] {P_IDLE, P_REQ, P_HOLD, P_DROP} upd_t;
    localparam logic [7:0] CU8   = 8'(CTRLUPD_ACK_DLY);
    localparam logic [7:0] HOLD8 = 8'(UPD_HOLD);
    localparam logic [7:0] RESP8 = 8'(TPHYUPD_RESP);
    upd_t       upd_state;
    logic [7:0] upd_cnt, cu_cnt;
    logic       ack_q, phy_go, cu_block;

    wav_dfi_phy_hs_lp #(.ACK_DLY(LP_ACK_DLY), .RESP(TLP_RESP)) u_lp_ctrl (
        .clock(clock), .reset(reset), .req(lp_ctrl_req), .init_start(init_start),
        .phy_busy(phy_busy), .wakeup(lp_ctrl_wakeup), .ack(lp_ctrl_ack), .wakeup_q(lp_ctrl_wakeup_q)
    );
    wav_dfi_phy_hs_lp #(.ACK_DLY(LP_ACK_DLY), .RESP(TLP_RESP)) u_lp_data (
        .clock(clock), .reset(reset), .req(lp_data_req), .init_start(init_start),
        .phy_busy(phy_busy), .wakeup(lp_data_wakeup), .ack(lp_data_ack), .wakeup_q(lp_data_wakeup_q)
    );

`ifdef WAV_DFI_PHYMSTR_EN
    upd_t       mstr_state;
    logic [7:0] mstr_cnt;
    logic       mstr_go;
    assign phy_go   = upd_state == P_IDLE && mstr_state == P_IDLE && upd_trig && !ack_q && !init_start;
    assign mstr_go  = mstr_state == P_IDLE && upd_state == P_IDLE && !phy_go && mstr_trig && !ack_q && !init_start;
    assign cu_block = phyupd_req | phy_go | phymstr_req | mstr_go;
    assign phymstr_cs_state  = phymstr_req ? 2'b11 : 2'b00;
    assign phymstr_state_sel = 1'b0;
    // PHY-master request FSM, same shape as phyupd without the response timer
    always_ff @(posedge clock) begin
        if (reset) begin
            mstr_state   <= P_IDLE;
            phymstr_req  <= 1'b0;
            phymstr_type <= 2'd0;
            mstr_cnt     <= 8'd0;
        end else begin
            case (mstr_state)
                P_IDLE: if (mstr_go) begin
                    mstr_state   <= P_REQ;
                    phymstr_req  <= 1'b1;
                    phymstr_type <= mstr_trig_type;
                end
                P_REQ: if (phymstr_ack) begin
                    mstr_state <= P_HOLD;
                    mstr_cnt   <= 8'd1;
                end
                P_HOLD: if (mstr_cnt == HOLD8) begin
                    phymstr_req <= 1'b0;
                    mstr_state  <= P_DROP;
                end else mstr_cnt <= mstr_cnt + 8'd1;
                P_DROP: if (!phymstr_ack) begin
                    mstr_state   <= P_IDLE;
                    phymstr_type <= 2'd0;
                end
                default: mstr_state <= P_IDLE;
            endcase
        end
    end
`else
    assign phy_go   = upd_state == P_IDLE && upd_trig && !ack_q && !init_start;
    assign cu_block = phyupd_req | phy_go;
`endif

    assign ctrlupd_ack = ack_q & ctrlupd_req;

    // ctrlupd ack timer; a PHY-side update starting or in flight holds the ack off
    always_ff @(posedge clock) begin
        if (reset || !ctrlupd_req) begin
            ack_q  <= 1'b0;
            cu_cnt <= 8'd0;
        end else begin
            if (cu_cnt != CU8) cu_cnt <= cu_cnt + 8'd1;
            if (cu_cnt + 8'd1 >= CU8 && !cu_block && !init_start) ack_q <= 1'b1;
        end
    end

    // phyupd FSM; upd_cnt counts request cycles in REQ and hold cycles in HOLD
    always_ff @(posedge clock) begin
        if (reset) begin
            upd_state      <= P_IDLE;
            phyupd_req     <= 1'b0;
            phyupd_type    <= 2'd0;
            phyupd_timeout <= 1'b0;
            upd_cnt        <= 8'd0;
        end else begin
            phyupd_timeout <= 1'b0;
            case (upd_state)
                P_IDLE: if (phy_go) begin
                    upd_state   <= P_REQ;
                    phyupd_req  <= 1'b1;
                    phyupd_type <= upd_trig_type;
                    upd_cnt     <= 8'd1;
                end
                P_REQ: if (phyupd_ack) begin
                    upd_state <= P_HOLD;
                    upd_cnt   <= 8'd1;
                end else begin
                    if (upd_cnt != 8'hFF) upd_cnt <= upd_cnt + 8'd1;
                    phyupd_timeout <= upd_cnt + 8'd1 == RESP8;
                end
                P_HOLD: if (upd_cnt == HOLD8) begin
                    phyupd_req <= 1'b0;
                    upd_state  <= P_DROP;
                end else upd_cnt <= upd_cnt + 8'd1;
                P_DROP: if (!phyupd_ack) begin
                    upd_state   <= P_IDLE;
                    phyupd_type <= 2'd0;
                end
                default: upd_state <= P_IDLE;
            endcase
        end
    end
endmodule
